// File: rtl/lab5_g30_debounce.sv
// -----------------------------------------------------------------------------
// lab5_g30_debounce
//
// Push-button / switch debouncer. The raw asynchronous level btn_in is
// synchronized through two flops and then qualified by a four-state FSM. A
// change in level is accepted only after the synchronized input has held the
// new value for DEBOUNCE_CYCLES consecutive clock cycles. Any shorter
// excursion is rejected and counted.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive synchronized cycles needed to accept a level
//                    change; legal range 2..255 (the counter is 8 bits wide).
//
// Ports
//   clk         in   single clock; all state updates on the rising edge
//   reset       in   asynchronous, active-high reset
//   btn_in      in   raw bouncing button level (asynchronous to clk)
//   A           out  debounced level; feeds the downstream sequence FSM
//   rise        out  one-cycle pulse when A goes 0->1
//   fall        out  one-cycle pulse when A goes 1->0
//   busy        out  high while a candidate change is being qualified
//   glitch_cnt  out  saturating count of rejected candidate changes
//
// Timing
//   With btn_in stable from sampling edge E1, sync_q shows the new level after
//   E2, the FSM leaves its stable state on E3 (cnt=1), and A changes on edge
//   E(DEBOUNCE_CYCLES+2). busy is therefore high for DEBOUNCE_CYCLES-1 cycles
//   ahead of the accepting edge.
// -----------------------------------------------------------------------------
module lab5_g30_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       A,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  // cnt value at which the candidate level is accepted.
  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] GlitchMax = 8'hFF;

  typedef enum logic [1:0] {
    StStableLo = 2'b00,
    StWaitHi   = 2'b01,
    StStableHi = 2'b10,
    StWaitLo   = 2'b11
  } state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. sync_meta may go metastable; only sync_q is used.
  // ---------------------------------------------------------------------------
  logic sync_meta;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync_q    <= sync_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Qualification FSM with registered outputs.
  // ---------------------------------------------------------------------------
  state_e     state;
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StStableLo;
      cnt        <= 8'd0;
      A          <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      glitch_cnt <= 8'd0;
    end else begin
      // Pulses last a single cycle unless re-asserted below.
      rise <= 1'b0;
      fall <= 1'b0;

      unique case (state)
        StStableLo: begin
          if (sync_q) begin
            state <= StWaitHi;
            cnt   <= 8'd1;
          end else begin
            cnt   <= 8'd0;
          end
        end

        StWaitHi: begin
          if (!sync_q) begin
            // Candidate rise did not hold: reject, A untouched.
            state <= StStableLo;
            cnt   <= 8'd0;
            if (glitch_cnt != GlitchMax) begin
              glitch_cnt <= glitch_cnt + 8'd1;
            end
          end else if (cnt == CntLast) begin
            state <= StStableHi;
            cnt   <= 8'd0;
            A     <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt   <= cnt + 8'd1;
          end
        end

        StStableHi: begin
          if (!sync_q) begin
            state <= StWaitLo;
            cnt   <= 8'd1;
          end else begin
            cnt   <= 8'd0;
          end
        end

        StWaitLo: begin
          if (sync_q) begin
            // Candidate fall did not hold: reject, A untouched.
            state <= StStableHi;
            cnt   <= 8'd0;
            if (glitch_cnt != GlitchMax) begin
              glitch_cnt <= glitch_cnt + 8'd1;
            end
          end else if (cnt == CntLast) begin
            state <= StStableLo;
            cnt   <= 8'd0;
            A     <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt   <= cnt + 8'd1;
          end
        end

        default: begin
          state <= StStableLo;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Decoded straight from the state register, so it is glitch-free and
  // clears asynchronously together with the state on reset.
  assign busy = (state == StWaitHi) || (state == StWaitLo);

`ifndef SYNTHESIS
  // rise and fall are mutually exclusive by construction.
  a_no_rise_and_fall : assert property (@(posedge clk) disable iff (reset) !(rise && fall));
`endif

endmodule
